// File: rtl/cmm_bsc_sfifo_wr_arb.sv
// -----------------------------------------------------------------------------
// cmm_bsc_sfifo_wr_arb
// Round-robin write-port arbiter that shares one synchronous FIFO between
// C_NUM requesters. A requester that starts a multi-beat burst keeps the write
// port until its last beat, or until C_MAXB beats force it to let go.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_vld       per-requester beat valid
//   req_last      per-requester last beat of burst
//   req_data      requester i data at bits [i*C_DW +: C_DW]
//   req_rdy       per-requester beat accepted (same-cycle handshake, one-hot)
//   fifo_wfull    FIFO full flag (hard backpressure)
//   fifo_awfull   FIFO almost-full flag (blocks new bursts only)
//   fifo_we       FIFO write enable
//   fifo_wdata    FIFO write data, zero when not writing
//   fifo_wid      index of the requester currently selected for writing
//   busy          high while a burst holds the lock
//   cur_owner     owner of the current or last burst
//   burst_err     one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module cmm_bsc_sfifo_wr_arb #(
    parameter int unsigned C_NUM  = 4,
    parameter int unsigned C_IDW  = 2,
    parameter int unsigned C_DW   = 32,
    parameter int unsigned C_MAXB = 16,
    parameter int unsigned C_CW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [C_NUM-1:0]      req_vld,
    input  logic [C_NUM-1:0]      req_last,
    input  logic [C_NUM*C_DW-1:0] req_data,
    output logic [C_NUM-1:0]      req_rdy,
    input  logic                  fifo_wfull,
    input  logic                  fifo_awfull,
    output logic                  fifo_we,
    output logic [C_DW-1:0]       fifo_wdata,
    output logic [C_IDW-1:0]      fifo_wid,
    output logic                  busy,
    output logic [C_IDW-1:0]      cur_owner,
    output logic                  burst_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [C_IDW-1:0] ptr_q, ptr_d;
    logic [C_IDW-1:0] owner_q, owner_d;
    logic [C_CW-1:0]  cnt_q, cnt_d;
    logic             burst_err_q, burst_err_d;

    logic             grant_found;
    logic [C_IDW-1:0] grant_idx;
    logic [C_IDW-1:0] sel_idx;
    logic             sel_last;
    logic             accept;

    // Round-robin successor of a requester index.
    function automatic logic [C_IDW-1:0] next_idx(input logic [C_IDW-1:0] i);
        if (int'(i) == int'(C_NUM) - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // First valid requester at or after ptr, wrapping at C_NUM.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < int'(C_NUM); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(C_NUM)) begin
                idx = idx - int'(C_NUM);
            end
            if (!grant_found && req_vld[idx]) begin
                grant_found = 1'b1;
                grant_idx   = C_IDW'(idx);
            end
        end
    end

    assign sel_idx  = (state_q == ST_LOCK) ? owner_q : grant_idx;
    assign sel_last = req_last[sel_idx];

    // Ready is gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        req_rdy = '0;
        if (rst_n) begin
            if (state_q == ST_LOCK) begin
                // An owned burst ignores almost-full and may fill the FIFO.
                req_rdy[owner_q] = ~fifo_wfull;
            end else if (!fifo_wfull && !fifo_awfull && grant_found) begin
                req_rdy[grant_idx] = 1'b1;
            end
        end
    end

    assign accept     = |(req_vld & req_rdy);
    assign fifo_we    = accept;
    assign fifo_wdata = accept ? req_data[sel_idx*C_DW +: C_DW] : '0;
    assign fifo_wid   = sel_idx;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        burst_err_d = 1'b0;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                owner_d = grant_idx;
                if (sel_last) begin
                    ptr_d = next_idx(grant_idx);
                end else begin
                    state_d = ST_LOCK;
                    cnt_d   = C_CW'(1);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(owner_q);
                end else if (cnt_q == C_CW'(C_MAXB - 1)) begin
                    // This is beat C_MAXB: force release, remainder re-arbitrates.
                    state_d     = ST_IDLE;
                    ptr_d       = next_idx(owner_q);
                    burst_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign busy      = (state_q == ST_LOCK);
    assign cur_owner = owner_q;
    assign burst_err = burst_err_q;

endmodule

// File: doc/cmm_bsc_sfifo_wr_arb.md
Name: cmm_bsc_sfifo_wr_arb

Overview:
Round-robin write-port arbiter that shares one synchronous FIFO between C_NUM requesters. It sits in front of the sync FIFO controller/RAM pair and drives its write enable and write data. It uses the FIFO's full and almost-full flags as backpressure. Bursts are packet-locked: once a requester starts a burst, it keeps the write port until its last beat or until a maximum beat count forces release.

Parameters:
C_NUM, 4, number of requesters (2..16)
C_IDW, 2, requester ID width, must be >= log2(C_NUM)
C_DW, 32, data width per requester
C_MAXB, 16, maximum beats per locked burst before forced release (>= 2)
C_CW, 5, beat counter width, must be >= log2(C_MAXB+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
req_vld  in  C_NUM  per-requester beat valid
req_last  in  C_NUM  per-requester last beat of burst
req_data  in  C_NUM*C_DW  requester i data at bits [i*C_DW +: C_DW]
req_rdy  out  C_NUM  per-requester beat accepted (same-cycle handshake)
fifo_wfull  in  1  FIFO full flag
fifo_awfull  in  1  FIFO almost-full flag
fifo_we  out  1  FIFO write enable
fifo_wdata  out  C_DW  FIFO write data
fifo_wid  out  C_IDW  ID of the requester whose beat is written
busy  out  1  1 while in LOCK
cur_owner  out  C_IDW  registered owner of the current or last burst
burst_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset is asynchronous, active low:
  - State goes to IDLE; ptr, owner, cnt and burst_err are 0.
  - While rst_n is low, req_rdy, fifo_we and fifo_wdata are forced to 0.
- Beat transfer: a beat is accepted when req_vld[i] & req_rdy[i].
  - fifo_we = OR of all accepted beats.
  - fifo_wdata and fifo_wid are the winner's data and index, combinationally in the same cycle (zero latency).
  - fifo_wdata is 0 when fifo_we is 0.
  - At most one req_rdy bit is high per cycle.
- IDLE:
  - Arbitration applies only when fifo_wfull=0 and fifo_awfull=0.
  - The grant g is the first i with req_vld[i]=1, searching from ptr upward and wrapping from C_NUM-1 to 0. req_rdy[g]=1 and the beat is written that cycle.
  - If req_last[g]=1 (single-beat burst): stay in IDLE; ptr <= (g+1) mod C_NUM; owner <= g.
  - Otherwise: go to LOCK; owner <= g; cnt <= 1.
  - If fifo_awfull=1 or fifo_wfull=1: no grant, all req_rdy=0, ptr unchanged.
- LOCK:
  - Only the owner is served: req_rdy[owner] = ~fifo_wfull. fifo_awfull is ignored, so an in-progress burst may fill the FIFO.
  - Other requesters see req_rdy=0.
  - An owner that deasserts req_vld keeps the lock indefinitely (no idle timeout).
  - On each accepted beat, cnt <= cnt+1.
  - Accepted beat with req_last=1: go to IDLE; ptr <= (owner+1) mod C_NUM.
  - Accepted beat with req_last=0 and cnt == C_MAXB-1 (this is beat C_MAXB): go to IDLE; ptr <= (owner+1) mod C_NUM; burst_err=1 for the next cycle only. The requester's remaining beats re-arbitrate as a new burst.
- busy = (state == LOCK), registered. cur_owner = owner register.
- Simultaneous events: when fifo_wfull rises during a beat, that beat is not accepted (req_rdy=0); it is retried when full drops, and no data is lost or duplicated. A request arriving the same cycle a burst ends waits one cycle, because arbitration happens only in IDLE.
- Overflow safety: fifo_we is never 1 while fifo_wfull=1.
- Fairness: each requester with continuous req_vld is granted within C_NUM-1 intervening bursts.

Test Plan:
1. C_NUM=4, FIFO empty, all four req_vld=1 with req_last=1 -> grants over 4 consecutive cycles with fifo_wid 0,1,2,3; ptr returns to 0; busy stays 0.
2. Requester 0 sends a 4-beat burst while requester 1 sends 1 beat from cycle 1 -> fifo_wid 0,0,0,0,1 in consecutive cycles; busy=1 for cycles 1..3; req_rdy[1]=0 until the burst ends.
3. fifo_wfull forced to 1 for 3 cycles after the 2nd beat of a 5-beat burst -> fifo_we=0 and req_rdy=0 for those 3 cycles; beats 3..5 follow in order; 5 writes total.
4. fifo_awfull=1 in IDLE with req_vld[2]=1 -> no grant. fifo_awfull=1 mid-burst in LOCK -> owner beats are still written until fifo_wfull=1.
5. C_MAXB=16, requester 1 streams 20 beats with no last while requester 3 is pending -> 16 writes with id 1, burst_err pulses once, the next burst goes to id 3, then id 1 resumes.
6. rst_n driven low during beat 2 of a burst -> req_rdy and fifo_we go to 0 immediately. After release: busy=0, ptr=0, a fresh request from id 0 is granted first.
